// File: rtl/tile_config_loader_if.sv
// tile_config_loader_if
// Purpose : groups the fabric-side configuration bus of one tile config loader.
// Signals : config_start  - one-cycle frame start pulse
//           config_enable - shift enable, one shift per cycle while high
//           config_in     - serial data, bit l feeds lane l
//           config_commit - shadow-latch request (CONFIG_SHADOW_EN builds)
//           config_out    - per-lane daisy-chain output
//           config_data   - configuration bus to the logic tile
//           config_done   - frame complete
//           config_error  - sticky commit-before-done flag
// Modports: master drives the bus (fabric side), slave is the loader.
interface tile_config_loader_if #(
  parameter int CONFIG_WIDTH = 524,
  parameter int LANES        = 1
);
  logic                    config_start;
  logic                    config_enable;
  logic [LANES-1:0]        config_in;
  logic                    config_commit;
  logic [LANES-1:0]        config_out;
  logic [CONFIG_WIDTH-1:0] config_data;
  logic                    config_done;
  logic                    config_error;

  modport master (
    output config_start, config_enable, config_in, config_commit,
    input  config_out, config_data, config_done, config_error
  );

  modport slave (
    input  config_start, config_enable, config_in, config_commit,
    output config_out, config_data, config_done, config_error
  );
endinterface

// File: rtl/tile_config_loader.sv
// tile_config_loader
// Purpose : loads a tile configuration frame over LANES parallel serial
//           sub-chains, counts shifts from config_start, flags completion and
//           exposes per-lane daisy-chain outputs for cascading tiles.
// Ports   : clock  - rising-edge clock
//           nreset - synchronous active-low reset
//           cfg    - tile_config_loader_if.slave configuration bus
// Option  : define CONFIG_SHADOW_EN to drive config_data from a shadow
//           register updated by config_commit (with config_error reporting).
//           Undefined: config_data is the shift register, commit ignored,
//           config_error tied low.
module tile_config_loader #(
  parameter int CONFIG_WIDTH = 524,
  parameter int LANES        = 1
) (
  input  logic                 clock,
  input  logic                 nreset,
  tile_config_loader_if.slave  cfg
);

  localparam int DEPTH = CONFIG_WIDTH / LANES;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  if ((CONFIG_WIDTH % LANES) != 0) begin : g_width_check
    $error("tile_config_loader: CONFIG_WIDTH must be a multiple of LANES");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  r_state, w_state_next;
  logic [CNT_W-1:0]        r_cnt, w_cnt_next;
  logic                    r_done, w_done_next;
  logic [CONFIG_WIDTH-1:0] r_sr, w_sr_next;

  // Each lane is an independent chain: new bit enters at the lane's LSB.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    if (DEPTH == 1) begin : g_single
      assign w_sr_next[l*DEPTH] = cfg.config_in[l];
    end else begin : g_chain
      assign w_sr_next[l*DEPTH +: DEPTH] =
        {r_sr[l*DEPTH +: DEPTH-1], cfg.config_in[l]};
    end
    assign cfg.config_out[l] = r_sr[l*DEPTH + DEPTH - 1];
  end

  // Data always passes through, independent of the frame state.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_sr <= '0;
    end else if (cfg.config_enable) begin
      r_sr <= w_sr_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_done_next  = r_done;
    if (cfg.config_start) begin
      // A shift coincident with start is the first counted shift of the new
      // frame; for a one-deep frame that shift already completes it.
      w_cnt_next = cfg.config_enable ? CNT_W'(1) : '0;
      if (cfg.config_enable && (DEPTH == 1)) begin
        w_state_next = DONE;
        w_done_next  = 1'b1;
      end else begin
        w_state_next = LOAD;
        w_done_next  = 1'b0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          w_cnt_next  = '0;
          w_done_next = 1'b0;
        end
        LOAD: begin
          if (cfg.config_enable) begin
            w_cnt_next = r_cnt + CNT_W'(1);
            if (w_cnt_next == DEPTH_C) begin
              w_state_next = DONE;
              w_done_next  = 1'b1;
            end
          end
        end
        DONE: begin
          w_cnt_next  = DEPTH_C;
          w_done_next = 1'b1;
        end
        default: begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
          w_done_next  = 1'b0;
        end
      endcase
    end
  end

  assign cfg.config_done = r_done;

`ifdef CONFIG_SHADOW_EN
  logic [CONFIG_WIDTH-1:0] r_shadow;
  logic                    r_error;

  // Start has priority over commit: a commit in the start cycle is dropped.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_shadow <= '0;
      r_error  <= 1'b0;
    end else if (cfg.config_start) begin
      r_error <= 1'b0;
    end else if (cfg.config_commit) begin
      if (r_done) begin
        r_shadow <= r_sr;
      end else begin
        r_error <= 1'b1;
      end
    end
  end

  assign cfg.config_data  = r_shadow;
  assign cfg.config_error = r_error;
`else
  logic w_unused_commit;
  assign w_unused_commit  = cfg.config_commit;
  assign cfg.config_data  = r_sr;
  assign cfg.config_error = 1'b0;
`endif

endmodule

// File: tb/tb_tile_config_loader.sv
// tb_tile_config_loader
// Purpose : directed self-checking bench for tile_config_loader, with a
//           4-lane 16-bit instance and a 1-lane 524-bit instance sharing a
//           clock and reset. Shadow checks are built with CONFIG_SHADOW_EN.
module tb_tile_config_loader;

  logic clock;
  logic nreset;
  int   n_checks;
  int   n_fail;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  tile_config_loader_if #(.CONFIG_WIDTH(16),  .LANES(4)) cfg4 ();
  tile_config_loader_if #(.CONFIG_WIDTH(524), .LANES(1)) cfg1 ();

  tile_config_loader #(.CONFIG_WIDTH(16), .LANES(4)) u_dut4 (
    .clock  (clock),
    .nreset (nreset),
    .cfg    (cfg4.slave)
  );

  tile_config_loader #(.CONFIG_WIDTH(524), .LANES(1)) u_dut1 (
    .clock  (clock),
    .nreset (nreset),
    .cfg    (cfg1.slave)
  );

  task automatic check(input string tag, input logic [527:0] obs,
                       input logic [527:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive4(input logic st, input logic en, input logic [3:0] din,
                        input logic cm);
    cfg4.config_start  = st;
    cfg4.config_enable = en;
    cfg4.config_in     = din;
    cfg4.config_commit = cm;
  endtask

  logic [527:0] exp_wide;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    nreset   = 1'b0;
    drive4(1'b0, 1'b0, 4'h0, 1'b0);
    cfg1.config_start  = 1'b0;
    cfg1.config_enable = 1'b0;
    cfg1.config_in     = 1'b0;
    cfg1.config_commit = 1'b0;

    // Reset with random activity on the inputs.
    for (int i = 0; i < 3; i++) begin
      drive4(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
      cfg1.config_start  = 1'($urandom);
      cfg1.config_enable = 1'($urandom);
      cfg1.config_in     = 1'($urandom);
      tick();
    end
    check("rst_data", cfg4.config_data, 16'h0000);
    check("rst_out",  cfg4.config_out,  4'h0);
    check("rst_done", cfg4.config_done, 1'b0);
    check("rst_err",  cfg4.config_error, 1'b0);
    check("rst_out1", cfg1.config_out, 1'b0);

    nreset = 1'b1;
    drive4(1'b0, 1'b0, 4'h0, 1'b0);
    cfg1.config_start  = 1'b0;
    cfg1.config_enable = 1'b0;
    cfg1.config_in     = 1'b0;
    tick();

    // Full frame.
    drive4(1'b1, 1'b0, 4'h0, 1'b0); tick();
    check("ff_done_start", cfg4.config_done, 1'b0);
    drive4(1'b0, 1'b1, 4'hF, 1'b0); tick();
    drive4(1'b0, 1'b1, 4'h0, 1'b0); tick();
    drive4(1'b0, 1'b1, 4'hF, 1'b0); tick();
    check("ff_done_3", cfg4.config_done, 1'b0);
    drive4(1'b0, 1'b1, 4'h0, 1'b0); tick();
    drive4(1'b0, 1'b0, 4'h0, 1'b0);
    check("ff_done_4", cfg4.config_done, 1'b1);
    check("ff_out",    cfg4.config_out,  4'hF);
`ifdef CONFIG_SHADOW_EN
    check("ff_data_precommit", cfg4.config_data, 16'h0000);
    drive4(1'b0, 1'b0, 4'h0, 1'b1); tick();
    drive4(1'b0, 1'b0, 4'h0, 1'b0);
    check("ff_err", cfg4.config_error, 1'b0);
`endif
    check("ff_data", cfg4.config_data, 16'hAAAA);

    // Passthrough after DONE.
    drive4(1'b0, 1'b1, 4'h5, 1'b0); tick();
    check("pt_out1", cfg4.config_out, 4'h0);
    tick();
    check("pt_out2", cfg4.config_out, 4'hF);
    tick();
    check("pt_out3", cfg4.config_out, 4'h0);
    tick();
    check("pt_out4", cfg4.config_out, 4'h5);
    check("pt_done", cfg4.config_done, 1'b1);
    drive4(1'b0, 1'b0, 4'h0, 1'b0); tick();
`ifdef CONFIG_SHADOW_EN
    check("pt_data", cfg4.config_data, 16'hAAAA);
`else
    check("pt_data", cfg4.config_data, 16'h0F0F);
`endif

    // Abort and restart.
    drive4(1'b1, 1'b0, 4'h0, 1'b0); tick();
    check("ab_done_start", cfg4.config_done, 1'b0);
    drive4(1'b0, 1'b1, 4'hF, 1'b0); tick();
    tick();
    check("ab_done_2", cfg4.config_done, 1'b0);
`ifdef CONFIG_SHADOW_EN
    drive4(1'b0, 1'b0, 4'h0, 1'b1); tick();
    check("ab_err_set",  cfg4.config_error, 1'b1);
    check("ab_data_hold", cfg4.config_data, 16'hAAAA);
`endif
    drive4(1'b1, 1'b1, 4'h1, 1'b0); tick();
    check("ab_done_re", cfg4.config_done, 1'b0);
    check("ab_err_clr", cfg4.config_error, 1'b0);
    drive4(1'b0, 1'b1, 4'h2, 1'b0); tick();
    check("ab_done_r2", cfg4.config_done, 1'b0);
    drive4(1'b0, 1'b1, 4'h4, 1'b0); tick();
    check("ab_done_r3", cfg4.config_done, 1'b0);
    drive4(1'b0, 1'b1, 4'h8, 1'b0); tick();
    drive4(1'b0, 1'b0, 4'h0, 1'b0);
    check("ab_done_r4", cfg4.config_done, 1'b1);
    check("ab_out",     cfg4.config_out,  4'h1);
`ifdef CONFIG_SHADOW_EN
    check("ab_data_precommit", cfg4.config_data, 16'hAAAA);
    drive4(1'b0, 1'b0, 4'h0, 1'b1); tick();
    check("ab_data_commit", cfg4.config_data, 16'h1248);
    check("ab_err_ok", cfg4.config_error, 1'b0);
    // Start and commit together: start wins, no error, shadow untouched.
    drive4(1'b1, 1'b1, 4'hF, 1'b1); tick();
    drive4(1'b0, 1'b0, 4'h0, 1'b0);
    check("sc_err",  cfg4.config_error, 1'b0);
    check("sc_done", cfg4.config_done,  1'b0);
    check("sc_data", cfg4.config_data,  16'h1248);
`else
    check("ab_data", cfg4.config_data, 16'h1248);
`endif

    // Single lane, full 524-bit frame; first bit emerges on shift 524.
    cfg1.config_start = 1'b1;
    tick();
    cfg1.config_start  = 1'b0;
    cfg1.config_enable = 1'b1;
    cfg1.config_in     = 1'b1;
    tick();
    cfg1.config_in = 1'b0;
    for (int i = 1; i < 523; i++) tick();
    check("l1_out_523",  cfg1.config_out,  1'b0);
    check("l1_done_523", cfg1.config_done, 1'b0);
    tick();
    cfg1.config_enable = 1'b0;
    check("l1_out_524",  cfg1.config_out,  1'b1);
    check("l1_done_524", cfg1.config_done, 1'b1);
`ifndef CONFIG_SHADOW_EN
    exp_wide      = '0;
    exp_wide[523] = 1'b1;
    check("l1_data", cfg1.config_data, exp_wide);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
